// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises rx_i, checks the start bit at mid-bit, shifts data in LSB-first,
// checks the stop bit and emits one byte per frame. Parity checking is compiled in with UART_PARITY_EN.
module uart_rx_deframer #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_i,
    input  logic              rx_en_i,
    input  logic [15:0]       clks_per_bit,
    input  logic              parity_odd_i,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              frame_err_o,
    output logic              parity_err_o,
    output logic              break_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;

    localparam int                IDX_W    = $clog2(DATA_W);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_W - 1);

    state_t              state;
    logic                rx_meta;
    logic                rx_s;
    logic [15:0]         cpb_q;
    logic [15:0]         cnt;
    logic [15:0]         half;
    logic [IDX_W-1:0]    bit_idx;
    logic [DATA_W-1:0]   shift;
    logic                bit_end;
    logic                start_mid;
    logic                all_zero;
`ifdef UART_PARITY_EN
    logic                par_bit;
    logic                par_mis;
`else
    logic                unused_parity_odd;
`endif

    assign half      = cpb_q >> 1;
    assign bit_end   = (cnt == cpb_q - 16'd1);
    assign start_mid = (cnt == half - 16'd1);
    assign busy_o    = (state != IDLE);

`ifdef UART_PARITY_EN
    assign all_zero = (shift == '0) && !par_bit;
`else
    assign all_zero = (shift == '0);
    assign unused_parity_odd = parity_odd_i;
`endif

    // NOTE: every register here is written with <= so all flops update together from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            state        <= IDLE;
            cpb_q        <= '0;
            cnt          <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            rx_data_o    <= '0;
            rx_valid_o   <= 1'b0;
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
            break_o      <= 1'b0;
`ifdef UART_PARITY_EN
            par_bit      <= 1'b0;
            par_mis      <= 1'b0;
`endif
        end else begin
            rx_meta      <= rx_i;
            rx_s         <= rx_meta;
            rx_valid_o   <= 1'b0;
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;

            if (state != IDLE && !rx_en_i) begin
                state   <= IDLE;
                cnt     <= '0;
                break_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_en_i && !rx_s) begin
                            state <= START;
                            cnt   <= '0;
                            cpb_q <= clks_per_bit;
                        end
                    end
                    START: begin
                        // A bit time under two clocks has no usable mid-point.
                        if (cpb_q < 16'd2) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (start_mid) begin
                            cnt <= '0;
                            if (!rx_s) begin
                                state   <= DATA;
                                bit_idx <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            cnt     <= '0;
                            shift   <= {rx_s, shift[DATA_W-1:1]};
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx == LAST_IDX) begin
`ifdef UART_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
`ifdef UART_PARITY_EN
                    PARITY: begin
                        if (bit_end) begin
                            cnt     <= '0;
                            par_bit <= rx_s;
                            par_mis <= (((^shift) ^ rx_s) != parity_odd_i);
                            state   <= STOP;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
`endif
                    STOP: begin
                        if (bit_end) begin
                            cnt         <= '0;
                            rx_valid_o  <= 1'b1;
                            rx_data_o   <= shift;
                            frame_err_o <= !rx_s;
`ifdef UART_PARITY_EN
                            parity_err_o <= par_mis;
`endif
                            if (!rx_s && all_zero) begin
                                break_o <= 1'b1;
                                state   <= BREAK_WAIT;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    BREAK_WAIT: begin
                        if (rx_s) begin
                            break_o <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
